// File: rtl/zprize_mul_credit_fifo.sv
// Credit-managed first-word-fallthrough FIFO behind a fixed-latency multiplier.
// Each credit reserves one slot for a product already issued to the multiplier.
module zprize_mul_credit_fifo #(
    parameter int PW      = 768,
    parameter int M       = 32,
    parameter int FD      = 16,
    parameter int MUL_LAT = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  issue,
    output logic                  issue_ok,
    input  logic [PW-1:0]         mul_out,
    input  logic [M-1:0]          mul_m,
    output logic [PW-1:0]         dout,
    output logic [M-1:0]          dout_m,
    output logic                  dout_valid,
    input  logic                  dout_ready,
    output logic [$clog2(FD):0]   occ,
    output logic [1:0]            err
);

    localparam int AW = $clog2(FD);
    localparam int BW = $clog2(MUL_LAT + 1);
    localparam logic [AW:0] FD_C = (AW + 1)'(FD);
    localparam logic [AW:0] ONE_P = (AW + 1)'(1);

    logic [PW+M-1:0] mem [FD];
    logic [PW+M-1:0] head;
    logic [AW:0]     wr_ptr;
    logic [AW:0]     rd_ptr;
    logic [AW:0]     credits;
    logic [AW:0]     credits_nxt;
    logic [BW-1:0]   blank;
    logic            push_req;
    logic            push;
    logic            pop;
    logic            full;
    logic            take;

    assign occ        = wr_ptr - rd_ptr;
    assign full       = (occ == FD_C);
    assign dout_valid = (occ != '0);
    assign pop        = dout_valid && dout_ready;
    // The multiplier's metadata pipe is not reset, so valid bits are distrusted until it has flushed.
    assign push_req   = mul_m[0] && (blank == '0);
    assign push       = push_req && (!full || pop);
    assign take       = issue && issue_ok;

    assign head   = mem[rd_ptr[AW-1:0]];
    assign dout   = dout_valid ? head[PW+M-1:M] : '0;
    assign dout_m = dout_valid ? head[M-1:0]    : '0;

    always_comb begin
        credits_nxt = credits;
        if (take && !pop) begin
            credits_nxt = credits - ONE_P;
        end else if (!take && pop && (credits != FD_C)) begin
            credits_nxt = credits + ONE_P;
        end
    end

    // Storage has no reset; validity is carried entirely by the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= {mul_out, mul_m};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            credits  <= FD_C;
            issue_ok <= 1'b1;
            err      <= '0;
            blank    <= BW'(MUL_LAT);
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + ONE_P;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + ONE_P;
            end
            credits  <= credits_nxt;
            issue_ok <= (credits_nxt != '0);
            if (blank != '0) begin
                blank <= blank - BW'(1);
            end
            if (issue && !issue_ok) begin
                err[0] <= 1'b1;
            end
            if (push_req && full && !pop) begin
                err[1] <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_zprize_mul_credit_fifo.sv
// Scoreboard bench: the bench plays the multiplier, queues expected tags, and a monitor checks pops.
module tb_zprize_mul_credit_fifo;

    localparam int PW  = 768;
    localparam int M   = 32;
    localparam int FD  = 16;
    localparam int LAT = 5;

    logic            clk = 1'b0;
    logic            rst;
    logic            issue;
    logic            issue_ok;
    logic [PW-1:0]   mul_out;
    logic [M-1:0]    mul_m;
    logic [PW-1:0]   dout;
    logic [M-1:0]    dout_m;
    logic            dout_valid;
    logic            dout_ready;
    logic [$clog2(FD):0] occ;
    logic [1:0]      err;

    int checks = 0;
    int errors = 0;
    int exp_q[$];
    bit pipe_v[LAT+1];
    int pipe_tag[LAT+1];
    bit force_v = 1'b0;
    int force_tag = 0;
    bit rdy = 1'b0;
    bit rdy_rand = 1'b0;
    int rcv = 0;
    int max_occ = 0;

    always #5 clk = ~clk;

    zprize_mul_credit_fifo #(.PW(PW), .M(M), .FD(FD), .MUL_LAT(LAT)) dut (
        .clk(clk), .rst(rst), .issue(issue), .issue_ok(issue_ok),
        .mul_out(mul_out), .mul_m(mul_m), .dout(dout), .dout_m(dout_m),
        .dout_valid(dout_valid), .dout_ready(dout_ready), .occ(occ), .err(err)
    );

    function automatic logic [PW-1:0] prod(input int t);
        logic [PW-1:0] p;
        for (int i = 0; i < PW / 32; i++) begin
            p[i*32 +: 32] = 32'hC0DE_0000 ^ (32'(t) * 32'(i + 1));
        end
        return p;
    endfunction

    function automatic logic [M-1:0] meta(input int t);
        logic [14:0] tt;
        tt = t[14:0];
        return {16'hBEEF, tt, 1'b1};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, act, expv);
        end
    endtask

    always @(negedge clk) begin
        int t;
        if (!rst) begin
            if (int'(occ) > max_occ) max_occ = int'(occ);
            if (dout_valid && dout_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL pop_unexpected got meta %h want none", dout_m);
                end else begin
                    t = exp_q.pop_front();
                    rcv++;
                    if (dout !== prod(t) || dout_m !== meta(t)) begin
                        errors++;
                        $display("FAIL pop_data got meta %h want %h", dout_m, meta(t));
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit iss, input bit pv, input int tag);
        for (int i = LAT; i > 0; i--) begin
            pipe_v[i]   = pipe_v[i-1];
            pipe_tag[i] = pipe_tag[i-1];
        end
        pipe_v[0]   = pv;
        pipe_tag[0] = tag;
        issue       = iss;
        dout_ready  = rdy_rand ? 1'($urandom_range(0, 1)) : rdy;
        if (force_v) begin
            mul_m   = meta(force_tag);
            mul_out = prod(force_tag);
        end else begin
            mul_m    = meta(pipe_tag[LAT]);
            mul_m[0] = pipe_v[LAT];
            mul_out  = prod(pipe_tag[LAT]);
        end
    endtask

    task automatic step(input bit iss, input bit pv, input int tag);
        tick();
        drive(iss, pv, tag);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0);
    endtask

    // One reset cycle, then LAT cycles with a valid product forced on mul_m.
    task automatic do_reset();
        tick();
        rst = 1'b1;
        drive(1'b0, 1'b0, 0);
        exp_q.delete();
        tick();
        rst = 1'b0;
        force_v = 1'b1;
        force_tag = 999;
        drive(1'b0, 1'b0, 0);
        for (int i = 1; i < LAT; i++) begin
            tick();
            drive(1'b0, 1'b0, 0);
        end
        tick();
        force_v = 1'b0;
        drive(1'b0, 1'b0, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int sent;
        int rcv0;
        for (int i = 0; i <= LAT; i++) begin
            pipe_v[i] = 1'b0;
            pipe_tag[i] = 0;
        end
        rst = 1'b1;
        force_v = 1'b1;
        force_tag = 7;
        drive(1'b0, 1'b0, 0);
        force_v = 1'b0;
        tick();
        drive(1'b0, 1'b0, 0);
        @(negedge clk);
        chk("rst_issue_ok", 64'(issue_ok), 64'd1);
        chk("rst_occ", 64'(occ), 64'd0);
        chk("rst_dout_valid", 64'(dout_valid), 64'd0);
        chk("rst_dout_zero", 64'(dout == '0), 64'd1);
        chk("rst_dout_m", 64'(dout_m), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        do_reset();
        @(negedge clk);
        chk("blank_occ", 64'(occ), 64'd0);
        chk("blank_err", 64'(err), 64'd0);

        // basic flow
        rdy = 1'b1;
        step(1'b1, 1'b1, 1);
        exp_q.push_back(1);
        idle(LAT);
        @(negedge clk);
        chk("basic_not_yet_valid", 64'(dout_valid), 64'd0);
        step(1'b0, 1'b0, 0);
        @(negedge clk);
        chk("basic_valid_lat_plus1", 64'(dout_valid), 64'd1);
        idle(2);
        @(negedge clk);
        chk("basic_occ_after_pop", 64'(occ), 64'd0);
        chk("basic_issue_ok", 64'(issue_ok), 64'd1);

        // credit exhaustion
        rdy = 1'b0;
        for (int i = 0; i < FD; i++) begin
            step(1'b1, 1'b1, 100 + i);
            exp_q.push_back(100 + i);
        end
        @(negedge clk);
        chk("exh_ok_during_16th", 64'(issue_ok), 64'd1);
        step(1'b1, 1'b0, 0);
        @(negedge clk);
        chk("exh_ok_after_16th", 64'(issue_ok), 64'd0);
        idle(LAT + 1);
        @(negedge clk);
        chk("exh_err", 64'(err), 64'd1);
        chk("exh_occ_full", 64'(occ), 64'd16);

        // full with same-cycle push and pop
        rdy = 1'b1;
        force_v = 1'b1;
        force_tag = 200;
        step(1'b0, 1'b0, 0);
        exp_q.push_back(200);
        force_v = 1'b0;
        rdy = 1'b0;
        step(1'b0, 1'b0, 0);
        @(negedge clk);
        chk("full_pp_occ", 64'(occ), 64'd16);
        chk("full_pp_err1", 64'(err[1]), 64'd0);
        rdy = 1'b1;
        idle(20);
        @(negedge clk);
        chk("full_drain_occ", 64'(occ), 64'd0);
        chk("full_drain_issue_ok", 64'(issue_ok), 64'd1);
        chk("full_drain_queue", 64'(exp_q.size()), 64'd0);
        do_reset();
        @(negedge clk);
        chk("reset_clears_err", 64'(err), 64'd0);

        // wrap-around with random ready
        rdy_rand = 1'b1;
        sent = 0;
        rcv0 = rcv;
        for (int c = 0; c < 3000 && (sent < 40 || exp_q.size() > 0); c++) begin
            tick();
            if (issue_ok && sent < 40) begin
                drive(1'b1, 1'b1, sent);
                exp_q.push_back(sent);
                sent++;
            end else begin
                drive(1'b0, 1'b0, 0);
            end
        end
        rdy_rand = 1'b0;
        rdy = 1'b0;
        step(1'b0, 1'b0, 0);
        @(negedge clk);
        chk("wrap_received", 64'(rcv - rcv0), 64'd40);
        chk("wrap_occ_bound", 64'(max_occ <= FD), 64'd1);
        chk("wrap_err", 64'(err), 64'd0);

        // reset mid-operation: 5 stored, 3 in flight
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b1, 400 + i);
            exp_q.push_back(400 + i);
        end
        idle(LAT);
        for (int i = 5; i < 8; i++) begin
            step(1'b1, 1'b1, 400 + i);
            exp_q.push_back(400 + i);
        end
        @(negedge clk);
        chk("mid_occ_before", 64'(occ), 64'd5);
        do_reset();
        @(negedge clk);
        chk("mid_occ_after", 64'(occ), 64'd0);
        chk("mid_valid_after", 64'(dout_valid), 64'd0);
        chk("mid_err_after", 64'(err), 64'd0);
        for (int i = 0; i < FD; i++) step(1'b1, 1'b0, 0);
        @(negedge clk);
        chk("mid_credits_16_left", 64'(issue_ok), 64'd1);
        step(1'b0, 1'b0, 0);
        @(negedge clk);
        chk("mid_credits_exact", 64'(issue_ok), 64'd0);
        do_reset();

        // forced overflow without issue
        rdy = 1'b0;
        force_v = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            force_tag = 500 + i;
            drive(1'b0, 1'b0, 0);
            if (i < FD) exp_q.push_back(500 + i);
        end
        force_v = 1'b0;
        step(1'b0, 1'b0, 0);
        @(negedge clk);
        chk("ovf_err", 64'(err), 64'd2);
        chk("ovf_occ", 64'(occ), 64'd16);
        chk("ovf_head", 64'(dout_m), 64'(meta(500)));
        rdy = 1'b1;
        idle(20);
        @(negedge clk);
        chk("ovf_drain_queue", 64'(exp_q.size()), 64'd0);
        chk("ovf_drain_occ", 64'(occ), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/zprize_mul_credit_fifo.md
ZPRIZE_MUL_CREDIT_FIFO -- requirements
Module: zprize_mul_credit_fifo

Interface
REQ-001 SHALL have parameter PW, default 768: product width; equals the upstream multiplier's W0+W1.
REQ-002 SHALL have parameter M, default 32: metadata width; bit 0 is the valid flag.
REQ-003 SHALL have parameter FD, default 16: FIFO depth; power of two, at least 2.
REQ-004 SHALL have parameter MUL_LAT, default 5: fixed multiplier latency in cycles, at least 1.
REQ-005 SHALL have port clk, input, 1: single clock for all logic.
REQ-006 SHALL have port rst, input, 1: reset; synchronous, active-high.
REQ-007 SHALL have port issue, input, 1: pulse; the operand pair entering the multiplier this cycle is valid.
REQ-008 SHALL have port issue_ok, output, 1: at least one credit is free; issue is permitted.
REQ-009 SHALL have port mul_out, input, PW: multiplier product.
REQ-010 SHALL have port mul_m, input, M: multiplier metadata; mul_m[0]=1 marks a valid product.
REQ-011 SHALL have port dout, output, PW: head product.
REQ-012 SHALL have port dout_m, output, M: head metadata.
REQ-013 SHALL have port dout_valid, output, 1: head entry present.
REQ-014 SHALL have port dout_ready, input, 1: consumer accepts the head.
REQ-015 SHALL have port occ, output, $clog2(FD)+1: number of stored entries.
REQ-016 SHALL have port err, output, 2: sticky flags; [0] issue without credit, [1] push while full.

Function
REQ-017 SHALL hold a credit counter in the range 0..FD; issue_ok = (credits != 0), driven from a register with no combinational path from any input.
REQ-018 SHALL apply credit updates per cycle:
  - issue && issue_ok: credits-1
  - pop: credits+1
  - both: unchanged
  - issue while credits==0: ignored, no decrement, err[0] set.
REQ-019 SHALL push the pair {mul_out, mul_m} when mul_m[0]=1, except while the post-reset blanking counter is nonzero (see REQ-026).
REQ-020 SHALL pop when dout_valid && dout_ready.
REQ-021 SHALL use first-word-fallthrough timing: an entry pushed into an empty FIFO appears on dout/dout_m/dout_valid in the next cycle.
REQ-022 SHALL implement a circular buffer with read/write pointers that wrap modulo FD; occ = write count minus read count, in the range 0..FD.
REQ-023 SHALL handle simultaneous push and pop as follows:
  - Occupancy is unchanged.
  - When full, the push is accepted because of the same-cycle pop.
  - When occ==1, the new entry becomes the head in the next cycle.
REQ-024 SHALL drop a push while full with no same-cycle pop; the stored contents are unchanged and err[1] is set.
REQ-025 SHALL keep dout/dout_m stable while dout_valid && !dout_ready; ordering is strictly first-in first-out.
REQ-026 SHALL hold a blanking counter loaded with MUL_LAT on reset and decremented each cycle to 0. While it is nonzero, mul_m[0] is ignored, because the multiplier metadata pipeline is not reset and may hold stale valid bits.
REQ-027 SHALL clear err only on rst.

Reset
REQ-028 SHALL, while rst=1 and in the following cycle, drive: credits=FD, issue_ok=1, occ=0, dout_valid=0, dout=0, dout_m=0, err=0, pointers=0, blanking counter=MUL_LAT.
REQ-029 SHALL, on reset mid-operation, discard all stored entries and restore all credits; products in flight are dropped by blanking, with no push and no err[1].

Verification
REQ-030 SHALL cover basic flow: issue once at cycle 0 and drive mul_m[0]=1 at cycle MUL_LAT with dout_ready=1 -> dout_valid=1 at cycle MUL_LAT+1 carrying the matching product and tag; credits return to FD after the pop.
REQ-031 SHALL cover credit exhaustion: issue 16 consecutive cycles (FD=16) with dout_ready=0 -> issue_ok=0 after the 16th issue; a 17th issue sets err[0]; occ reaches 16 with no err[1].
REQ-032 SHALL cover full plus simultaneous event: FIFO full, push and pop in the same cycle -> occ stays 16, order preserved, err=0.
REQ-033 SHALL cover pointer wrap-around: stream 40 tagged products (tags 0..39) with random dout_ready -> output tags 0..39 in order, occ never exceeds 16.
REQ-034 SHALL cover reset mid-operation: assert rst with occ=5 and 3 products in flight -> occ=0, credits=16, and no entry pushed during the following MUL_LAT cycles even with mul_m[0]=1.
REQ-035 SHALL cover forced overflow: drive mul_m[0]=1 without any issue until full and beyond -> err[1]=1 and the stored data is unchanged.
